reg_file_tracked: RTL and testbench
===================================

Name: reg_file_tracked

Overview:
- Parametrised successor to the team's 8x8 single-port register file.
- Generalises data width and depth, and adds a per-entry invalidate command.
- Adds a classified error code, an occupancy count and a saturating error counter.
- Sits as a small flip-flop configuration/scratch store behind a simple rd/wr command interface; one command per cycle.

Parameters:
DATA_W, 8, data width in bits (>=1)
DEPTH, 8, number of entries (>=2, need not be a power of two)
ADDR_W, $clog2(DEPTH), address width (derived; do not override)
ERRCNT_W, 8, width of saturating error counter

Ports:
clk  input  1  clock, all logic on rising edge
resetn  input  1  reset, synchronous, active-low
din  input  DATA_W  write data
addr  input  ADDR_W  entry address for wr/rd/clr
wr  input  1  write command
rd  input  1  read command
clr  input  1  invalidate command (clears valid bit of addr)
dout  output  DATA_W  read data
dout_valid  output  1  dout holds data of a valid entry
error  output  1  one-cycle pulse: last command rejected or read of unwritten entry
err_code  output  2  00 none, 01 command conflict, 10 read of invalid entry, 11 address out of range
used  output  ADDR_W+1  number of valid entries
err_cnt  output  ERRCNT_W  errors since reset, saturates at all-ones

Behaviour:
- Reset (resetn=0 at clk edge): all valid bits 0; dout=0, dout_valid=0, error=0, err_code=00, used=0, err_cnt=0. Memory contents not reset; unreadable until rewritten. Reset overrides any command in the same cycle.
- Command decode, in priority order, evaluated each cycle:
  1. Two or more of wr/rd/clr high -> conflict: no state change, error=1, err_code=01.
  2. addr >= DEPTH with any command -> error=1, err_code=11, no state change.
  3. wr -> mem[addr]<=din, valid[addr]<=1; used+1 only if entry was invalid.
  4. clr -> valid[addr]<=0; used-1 only if entry was valid; clearing an invalid entry is a no-op with no error.
  5. rd, valid entry -> dout<=mem[addr], dout_valid=1.
  6. rd, invalid entry -> dout=0, dout_valid=0, error=1, err_code=10.
- Output defaults:
  - dout=0 and dout_valid=0 every cycle that is not a successful read.
  - error/err_code return to 0/00 in the cycle after any non-error command or idle.
- Read latency: 1 cycle (registered outputs).
- Memory array:
  - Read-after-write to the same address on the next cycle returns the new data.
  - There is no same-cycle bypass, since wr and rd together is a conflict.
- err_cnt increments by 1 on every cycle with error=1 being set; it holds at 2^ERRCNT_W-1.
- used bounds:
  - Never exceeds DEPTH; overwriting a valid entry at used=DEPTH leaves it at DEPTH.
  - Never underflows; a clr at used=0 is a no-op.

Optional Feature:
- Macro REGFILE_OUT_PIPE_EN.
- Defined: one extra output register stage on dout, dout_valid, error and err_code. Read and error latency becomes 2 cycles. used and err_cnt timing is unchanged. The pipe stage is cleared by reset.
- Undefined: latency 1 as above.

Decomposition:
- Package reg_file_pkg holds:
  - typedef enum logic [1:0] err_code_t with ERR_NONE, ERR_CONFLICT, ERR_INVALID, ERR_RANGE.
  - Default parameter constants.
- Sub-module reg_file_valid_tracker:
  - Contains the valid bit vector and the used counter.
  - Inputs: set/clear strobes plus an index.
  - Outputs: valid vector and used.
- Top level holds data storage, command decode, output registers and err_cnt.

Test Plan:
- DEPTH=8, DATA_W=8: reset, then write 0xA5 to addr 3; rd addr 3 next cycle -> dout=0xA5, dout_valid=1, error=0 one cycle later; used=1.
- rd addr 5 (never written) -> dout=0x00, dout_valid=0, error=1, err_code=10; err_cnt=1.
- wr=1 and rd=1 at addr 2 with din=0x3C -> error=1, err_code=01; a subsequent rd addr 2 yields err_code=10, proving nothing was written.
- Write all 8 entries -> used=8; overwrite addr 0 -> used=8; clr addr 0 twice -> used=7 with no error; rd addr 0 -> err_code=10.
- DEPTH=6: wr addr 7 -> error=1, err_code=11, used unchanged. Force 300 conflict cycles with ERRCNT_W=8 -> err_cnt=255.
- Write addr 1=0x11, then assert resetn=0 concurrently with rd addr 1 -> outputs all zero, used=0; after reset, rd addr 1 -> err_code=10. Repeat with REGFILE_OUT_PIPE_EN defined and check 2-cycle latency.

Source files
------------

// File: rtl/reg_file_pkg.sv
// reg_file_pkg -- shared types and default sizes for the tracked register file.
//   err_code_t : classified error code reported on err_code
//   DEF_*      : default parameter values used by the interface and the top
package reg_file_pkg;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_CONFLICT = 2'b01,
    ERR_INVALID  = 2'b10,
    ERR_RANGE    = 2'b11
  } err_code_t;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_DEPTH    = 8;
  localparam int DEF_ERRCNT_W = 8;

endpackage

// File: rtl/reg_file_tracked_if.sv
// reg_file_tracked_if -- command/response bundle of the tracked register file.
//   master modport: drives din/addr/wr/rd/clr, observes the results
//   slave modport : the register file side
//   din/addr/wr/rd/clr : one command per cycle
//   dout/dout_valid    : read data and its validity
//   error/err_code     : one-cycle error pulse and its class
//   used/err_cnt       : occupancy and saturating error count
interface reg_file_tracked_if
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ERRCNT_W = DEF_ERRCNT_W
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [DATA_W-1:0]   din;
  logic [ADDR_W-1:0]   addr;
  logic                wr;
  logic                rd;
  logic                clr;
  logic [DATA_W-1:0]   dout;
  logic                dout_valid;
  logic                error;
  err_code_t           err_code;
  logic [ADDR_W:0]     used;
  logic [ERRCNT_W-1:0] err_cnt;

  modport master (
    output din, addr, wr, rd, clr,
    input  dout, dout_valid, error, err_code, used, err_cnt
  );

  modport slave (
    input  din, addr, wr, rd, clr,
    output dout, dout_valid, error, err_code, used, err_cnt
  );

endinterface

// File: rtl/reg_file_valid_tracker.sv
// reg_file_valid_tracker -- per-entry valid bits and the count of valid entries.
//   clk, resetn : clock and synchronous active-low reset
//   set, clear  : mark entry idx valid / invalid (never both in one cycle)
//   idx         : entry index, already range-checked by the caller
//   valid       : valid bit per entry
//   used        : number of valid entries; moves only when a bit actually flips
module reg_file_valid_tracker #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              set,
  input  logic              clear,
  input  logic [ADDR_W-1:0] idx,
  output logic [DEPTH-1:0]  valid,
  output logic [ADDR_W:0]   used
);

  localparam logic [ADDR_W:0] USED_ONE = (ADDR_W+1)'(1);

  // Valid vector and occupancy; the count follows bit transitions only, so
  // re-writing a valid entry or clearing an invalid one leaves it unchanged.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid <= '0;
      used  <= '0;
    end else if (set) begin
      if (!valid[idx]) begin
        used <= used + USED_ONE;
      end
      valid[idx] <= 1'b1;
    end else if (clear) begin
      if (valid[idx]) begin
        used <= used - USED_ONE;
      end
      valid[idx] <= 1'b0;
    end
  end

endmodule

// File: rtl/reg_file_tracked.sv
// reg_file_tracked -- parametrised flip-flop register file with valid tracking.
//   clk    : clock, rising edge
//   resetn : synchronous active-low reset (clears valid bits, outputs, counters;
//            memory contents are kept but unreadable until rewritten)
//   bus    : reg_file_tracked_if.slave (din/addr/wr/rd/clr in,
//            dout/dout_valid/error/err_code/used/err_cnt out)
// Build option: define REGFILE_OUT_PIPE_EN to add one more register stage on
// dout, dout_valid, error and err_code (latency 2 instead of 1); used and
// err_cnt keep their timing.
module reg_file_tracked
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ERRCNT_W = DEF_ERRCNT_W
) (
  input  logic              clk,
  input  logic              resetn,
  reg_file_tracked_if.slave bus
);

  localparam logic [ADDR_W:0]     DEPTH_V = (ADDR_W+1)'(DEPTH);
  localparam logic [ERRCNT_W-1:0] CNT_ONE = ERRCNT_W'(1);

  logic [DATA_W-1:0]   mem_r [DEPTH];
  logic [DEPTH-1:0]    valid_s;
  logic [ADDR_W:0]     used_s;

  logic                conflict_s;
  logic                any_cmd_s;
  logic                in_range_s;
  logic                set_s;
  logic                clear_s;
  logic                rd_ok_s;
  logic                err_s;
  err_code_t           code_s;

  logic [DATA_W-1:0]   dout_r;
  logic                dout_valid_r;
  logic                error_r;
  err_code_t           err_code_r;
  logic [ERRCNT_W-1:0] err_cnt_r;

  assign conflict_s = (bus.wr & bus.rd) | (bus.wr & bus.clr) | (bus.rd & bus.clr);
  assign any_cmd_s  = bus.wr | bus.rd | bus.clr;
  assign in_range_s = ({1'b0, bus.addr} < DEPTH_V);

  // Prioritised command decode: conflict, range, write, clear, read.
  always_comb begin
    set_s   = 1'b0;
    clear_s = 1'b0;
    rd_ok_s = 1'b0;
    err_s   = 1'b0;
    code_s  = ERR_NONE;
    if (conflict_s) begin
      err_s  = 1'b1;
      code_s = ERR_CONFLICT;
    end else if (any_cmd_s && !in_range_s) begin
      err_s  = 1'b1;
      code_s = ERR_RANGE;
    end else if (bus.wr) begin
      set_s = 1'b1;
    end else if (bus.clr) begin
      clear_s = 1'b1;
    end else if (bus.rd) begin
      if (valid_s[bus.addr]) begin
        rd_ok_s = 1'b1;
      end else begin
        err_s  = 1'b1;
        code_s = ERR_INVALID;
      end
    end else begin
      code_s = ERR_NONE;
    end
  end

  reg_file_valid_tracker #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_tracker (
    .clk    (clk),
    .resetn (resetn),
    .set    (set_s),
    .clear  (clear_s),
    .idx    (bus.addr),
    .valid  (valid_s),
    .used   (used_s)
  );

  // Data storage: no reset, a write during reset is suppressed.
  always_ff @(posedge clk) begin
    if (resetn && set_s) begin
      mem_r[bus.addr] <= bus.din;
    end
  end

  // First output stage and saturating error counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      dout_r       <= '0;
      dout_valid_r <= 1'b0;
      error_r      <= 1'b0;
      err_code_r   <= ERR_NONE;
      err_cnt_r    <= '0;
    end else begin
      dout_r       <= rd_ok_s ? mem_r[bus.addr] : '0;
      dout_valid_r <= rd_ok_s;
      error_r      <= err_s;
      err_code_r   <= code_s;
      if (err_s && (err_cnt_r != '1)) begin
        err_cnt_r <= err_cnt_r + CNT_ONE;
      end
    end
  end

`ifdef REGFILE_OUT_PIPE_EN
  logic [DATA_W-1:0] dout_p_r;
  logic              dout_valid_p_r;
  logic              error_p_r;
  err_code_t         err_code_p_r;

  // Extra output stage, flushed by reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      dout_p_r       <= '0;
      dout_valid_p_r <= 1'b0;
      error_p_r      <= 1'b0;
      err_code_p_r   <= ERR_NONE;
    end else begin
      dout_p_r       <= dout_r;
      dout_valid_p_r <= dout_valid_r;
      error_p_r      <= error_r;
      err_code_p_r   <= err_code_r;
    end
  end

  assign bus.dout       = dout_p_r;
  assign bus.dout_valid = dout_valid_p_r;
  assign bus.error      = error_p_r;
  assign bus.err_code   = err_code_p_r;
`else
  assign bus.dout       = dout_r;
  assign bus.dout_valid = dout_valid_r;
  assign bus.error      = error_r;
  assign bus.err_code   = err_code_r;
`endif

  assign bus.used    = used_s;
  assign bus.err_cnt = err_cnt_r;

endmodule

// File: tb/tb_reg_file_tracked.sv
// tb_reg_file_tracked -- table-driven bench with an output scoreboard for the
// DEPTH=8 instance, plus hand sequences on a DEPTH=6 instance for address range
// errors and err_cnt saturation. Works with or without REGFILE_OUT_PIPE_EN.
module tb_reg_file_tracked;

`ifdef REGFILE_OUT_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [7:0] dout;
    logic       dv;
    logic       err;
    logic [1:0] code;
  } exp_t;

  typedef struct {
    logic       wr;
    logic       rd;
    logic       clr;
    logic [2:0] addr;
    logic [7:0] din;
    exp_t       e;
    logic [3:0] e_used;
  } vec_t;

  localparam int N = 27;

  logic clk;
  logic resetn8;
  logic resetn6;
  int   n_vec;
  int   n_bad;
  int   exp_errs;
  exp_t sbq[$];
  exp_t zero_e;
  vec_t tbl [N];

  reg_file_tracked_if #(.DATA_W(8), .DEPTH(8), .ERRCNT_W(8)) bus8 ();
  reg_file_tracked_if #(.DATA_W(8), .DEPTH(6), .ERRCNT_W(8)) bus6 ();

  reg_file_tracked #(.DATA_W(8), .DEPTH(8), .ERRCNT_W(8)) u8 (
    .clk    (clk),
    .resetn (resetn8),
    .bus    (bus8)
  );

  reg_file_tracked #(.DATA_W(8), .DEPTH(6), .ERRCNT_W(8)) u6 (
    .clk    (clk),
    .resetn (resetn6),
    .bus    (bus6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic r, input logic c,
                              input logic [2:0] a, input logic [7:0] d,
                              input logic [7:0] ed, input logic edv,
                              input logic ee, input logic [1:0] ec,
                              input logic [3:0] eu);
    vec_t v;
    v.wr = w; v.rd = r; v.clr = c; v.addr = a; v.din = d;
    v.e.dout = ed; v.e.dv = edv; v.e.err = ee; v.e.code = ec;
    v.e_used = eu;
    return v;
  endfunction

  // One cycle on the DEPTH=8 instance: drive, queue the expectation, then
  // compare whatever result is due LAT cycles after its command.
  task automatic cycle8(input string tag, input logic w, input logic r, input logic c,
                        input logic [2:0] a, input logic [7:0] d,
                        input exp_t e, input logic rst);
    exp_t x;
    @(negedge clk);
    resetn8   = ~rst;
    bus8.wr   = w;
    bus8.rd   = r;
    bus8.clr  = c;
    bus8.addr = a;
    bus8.din  = d;
    if (rst) begin
      foreach (sbq[k]) sbq[k] = zero_e;
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() >= LAT) begin
      x = sbq.pop_front();
      chk({tag, ".dout"},  32'(bus8.dout),       32'(x.dout));
      chk({tag, ".dv"},    32'(bus8.dout_valid), 32'(x.dv));
      chk({tag, ".err"},   32'(bus8.error),      32'(x.err));
      chk({tag, ".code"},  32'(bus8.err_code),   32'(x.code));
    end
  endtask

  task automatic drive6(input logic rst, input logic w, input logic r, input logic c,
                        input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    resetn6   = ~rst;
    bus6.wr   = w;
    bus6.rd   = r;
    bus6.clr  = c;
    bus6.addr = a;
    bus6.din  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    exp_errs = 0;
    zero_e = '{8'h00, 1'b0, 1'b0, 2'b00};
    resetn8 = 1'b0; resetn6 = 1'b0;
    bus8.wr = 1'b0; bus8.rd = 1'b0; bus8.clr = 1'b0; bus8.addr = 3'd0; bus8.din = 8'h00;
    bus6.wr = 1'b0; bus6.rd = 1'b0; bus6.clr = 1'b0; bus6.addr = 3'd0; bus6.din = 8'h00;

    //          wr rd clr addr  din     dout   dv err code   used
    tbl[0]  = mk(1, 0, 0, 3'd3, 8'hA5, 8'h00, 0, 0, 2'b00, 4'd1);
    tbl[1]  = mk(0, 1, 0, 3'd3, 8'h00, 8'hA5, 1, 0, 2'b00, 4'd1);
    tbl[2]  = mk(0, 1, 0, 3'd5, 8'h00, 8'h00, 0, 1, 2'b10, 4'd1);
    tbl[3]  = mk(0, 0, 0, 3'd0, 8'h00, 8'h00, 0, 0, 2'b00, 4'd1);
    tbl[4]  = mk(1, 1, 0, 3'd2, 8'h3C, 8'h00, 0, 1, 2'b01, 4'd1);
    tbl[5]  = mk(0, 1, 0, 3'd2, 8'h00, 8'h00, 0, 1, 2'b10, 4'd1);
    tbl[6]  = mk(1, 0, 0, 3'd0, 8'h10, 8'h00, 0, 0, 2'b00, 4'd2);
    tbl[7]  = mk(1, 0, 0, 3'd1, 8'h11, 8'h00, 0, 0, 2'b00, 4'd3);
    tbl[8]  = mk(1, 0, 0, 3'd2, 8'h12, 8'h00, 0, 0, 2'b00, 4'd4);
    tbl[9]  = mk(1, 0, 0, 3'd3, 8'h13, 8'h00, 0, 0, 2'b00, 4'd4);
    tbl[10] = mk(1, 0, 0, 3'd4, 8'h14, 8'h00, 0, 0, 2'b00, 4'd5);
    tbl[11] = mk(1, 0, 0, 3'd5, 8'h15, 8'h00, 0, 0, 2'b00, 4'd6);
    tbl[12] = mk(1, 0, 0, 3'd6, 8'h16, 8'h00, 0, 0, 2'b00, 4'd7);
    tbl[13] = mk(1, 0, 0, 3'd7, 8'h17, 8'h00, 0, 0, 2'b00, 4'd8);
    tbl[14] = mk(1, 0, 0, 3'd0, 8'hEE, 8'h00, 0, 0, 2'b00, 4'd8);
    tbl[15] = mk(0, 1, 0, 3'd0, 8'h00, 8'hEE, 1, 0, 2'b00, 4'd8);
    tbl[16] = mk(0, 0, 1, 3'd0, 8'h00, 8'h00, 0, 0, 2'b00, 4'd7);
    tbl[17] = mk(0, 0, 1, 3'd0, 8'h00, 8'h00, 0, 0, 2'b00, 4'd7);
    tbl[18] = mk(0, 1, 0, 3'd0, 8'h00, 8'h00, 0, 1, 2'b10, 4'd7);
    tbl[19] = mk(0, 1, 0, 3'd7, 8'h00, 8'h17, 1, 0, 2'b00, 4'd7);
    tbl[20] = mk(1, 0, 1, 3'd1, 8'hFF, 8'h00, 0, 1, 2'b01, 4'd7);
    tbl[21] = mk(0, 1, 1, 3'd1, 8'h00, 8'h00, 0, 1, 2'b01, 4'd7);
    tbl[22] = mk(0, 1, 0, 3'd1, 8'h00, 8'h11, 1, 0, 2'b00, 4'd7);
    tbl[23] = mk(1, 0, 0, 3'd3, 8'h5A, 8'h00, 0, 0, 2'b00, 4'd7);
    tbl[24] = mk(0, 1, 0, 3'd3, 8'h00, 8'h5A, 1, 0, 2'b00, 4'd7);
    tbl[25] = mk(1, 1, 1, 3'd4, 8'h99, 8'h00, 0, 1, 2'b01, 4'd7);
    tbl[26] = mk(0, 1, 0, 3'd4, 8'h00, 8'h14, 1, 0, 2'b00, 4'd7);

    // Reset state of the DEPTH=8 instance.
    cycle8("rst0", 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, zero_e, 1'b1);
    cycle8("rst1", 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, zero_e, 1'b1);
    chk("rst.used",    32'(bus8.used),    32'd0);
    chk("rst.err_cnt", 32'(bus8.err_cnt), 32'd0);

    for (int i = 0; i < N; i++) begin
      cycle8($sformatf("v%0d", i), tbl[i].wr, tbl[i].rd, tbl[i].clr,
             tbl[i].addr, tbl[i].din, tbl[i].e, 1'b0);
      if (tbl[i].e.err) exp_errs++;
      chk($sformatf("v%0d.used", i),    32'(bus8.used),    32'(tbl[i].e_used));
      chk($sformatf("v%0d.err_cnt", i), 32'(bus8.err_cnt), 32'(exp_errs));
    end
    repeat (LAT) cycle8("drain", 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, zero_e, 1'b0);

    // Reset concurrent with a read of a valid entry (addr 1 = 0x11).
    cycle8("rstrd", 1'b0, 1'b1, 1'b0, 3'd1, 8'h00, zero_e, 1'b1);
    exp_errs = 0;
    chk("rstrd.used",    32'(bus8.used),    32'd0);
    chk("rstrd.err_cnt", 32'(bus8.err_cnt), 32'd0);
    cycle8("post0", 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, zero_e, 1'b0);
    cycle8("post1", 1'b0, 1'b1, 1'b0, 3'd1, 8'h00, '{8'h00, 1'b0, 1'b1, 2'b10}, 1'b0);
    chk("post1.err_cnt", 32'(bus8.err_cnt), 32'd1);
    repeat (LAT) cycle8("drain2", 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, zero_e, 1'b0);

    // DEPTH=6 instance: range errors, clr at used=0, err_cnt saturation.
    drive6(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    drive6(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    chk("d6.rst.used", 32'(bus6.used), 32'd0);
    drive6(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00);
    chk("d6.clr0.used", 32'(bus6.used), 32'd0);
    repeat (LAT - 1) drive6(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    chk("d6.clr0.err", 32'(bus6.error), 32'd0);
    drive6(1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 8'h42);
    chk("d6.wr2.used", 32'(bus6.used), 32'd1);
    drive6(1'b0, 1'b1, 1'b0, 1'b0, 3'd7, 8'h77);
    chk("d6.wr7.used",    32'(bus6.used),    32'd1);
    chk("d6.wr7.err_cnt", 32'(bus6.err_cnt), 32'd1);
    repeat (LAT - 1) drive6(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    chk("d6.wr7.err",  32'(bus6.error),    32'd1);
    chk("d6.wr7.code", 32'(bus6.err_code), 32'd3);
    drive6(1'b0, 1'b0, 1'b1, 1'b0, 3'd6, 8'h00);
    chk("d6.rd6.err_cnt", 32'(bus6.err_cnt), 32'd2);
    repeat (LAT - 1) drive6(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    chk("d6.rd6.err",  32'(bus6.error),    32'd1);
    chk("d6.rd6.code", 32'(bus6.err_code), 32'd3);
    drive6(1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 8'h00);
    repeat (LAT - 1) drive6(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    chk("d6.rd2.dout", 32'(bus6.dout),       32'h42);
    chk("d6.rd2.dv",   32'(bus6.dout_valid), 32'd1);
    chk("d6.rd2.err",  32'(bus6.error),      32'd0);
    for (int k = 0; k < 300; k++) begin
      drive6(1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 8'h00);
      if (k == 99) chk("d6.cf100.err_cnt", 32'(bus6.err_cnt), 32'd102);
      if (k == 252) chk("d6.cf253.err_cnt", 32'(bus6.err_cnt), 32'd255);
    end
    drive6(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    repeat (LAT) drive6(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    chk("d6.sat.err_cnt", 32'(bus6.err_cnt), 32'd255);
    chk("d6.sat.err",     32'(bus6.error),   32'd0);
    chk("d6.sat.code",    32'(bus6.err_code), 32'd0);
    chk("d6.sat.used",    32'(bus6.used),    32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
